// File: rtl/mosaic_pkg.sv
// Shared types, default geometry and width helpers for the mosaic scan generator.
package mosaic_pkg;

  localparam int DEF_IMG_W      = 640;
  localparam int DEF_IMG_H      = 480;
  localparam int TILES_X        = 4;
  localparam int TILES_Y        = 4;
  localparam int DEF_TILE_W     = DEF_IMG_W / TILES_X;
  localparam int DEF_TILE_H     = DEF_IMG_H / TILES_Y;
  localparam int DEF_PIPE_DEPTH = 4;

  // Coordinate fields are wide enough for any practical mosaic dimension.
  localparam int COORD_W = 16;

  // Bit width needed to hold 0..n-1, never narrower than one bit so that
  // degenerate geometries (a single tile, depth 1) still give legal vectors.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ADDR_W = width_of(DEF_IMG_W * DEF_IMG_H);

  typedef enum logic [1:0] {
    SCAN,
    DRAIN,
    FINISHED
  } scan_state_t;

  // Generic two-level position: col is the fast index, row the slow one.
  typedef struct packed {
    logic [COORD_W-1:0] col;
    logic [COORD_W-1:0] row;
  } tile_coord_t;

endpackage

// File: rtl/mosaic_scan_gen_tile_raster_counter.sv
// Two-level wrap counter: inner index runs 0..INNER_N-1, and each inner wrap
// steps the outer index 0..OUTER_N-1. wrap flags the advance that rolls both.
module tile_raster_counter
  import mosaic_pkg::*;
#(
  parameter int INNER_N = 2,
  parameter int OUTER_N = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  output tile_coord_t pos,
  output logic        wrap
);

  localparam logic [COORD_W-1:0] INNER_LAST = COORD_W'(INNER_N - 1);
  localparam logic [COORD_W-1:0] OUTER_LAST = COORD_W'(OUTER_N - 1);

  logic [COORD_W-1:0] inner_q, inner_d;
  logic [COORD_W-1:0] outer_q, outer_d;
  logic               inner_end, outer_end;

  // Next-position logic: step inner, carry into outer, roll both at the end.
  always_comb begin
    inner_end = (inner_q == INNER_LAST);
    outer_end = (outer_q == OUTER_LAST);
    wrap      = advance && inner_end && outer_end;
    inner_d   = inner_q;
    outer_d   = outer_q;
    if (advance) begin
      if (inner_end) begin
        inner_d = '0;
        outer_d = outer_end ? '0 : outer_q + 1'b1;
      end else begin
        inner_d = inner_q + 1'b1;
      end
    end
  end

  // Position registers, cleared to the first element on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      inner_q <= '0;
      outer_q <= '0;
    end else begin
      inner_q <= inner_d;
      outer_q <= outer_d;
    end
  end

  assign pos = '{col: inner_q, row: outer_q};

endmodule

// File: rtl/mosaic_scan_gen.sv
// Source-side scan sequencer: walks the mosaic tile by tile emitting one
// coordinate/address beat per handshake, then drains the pipeline and pulses done.
module mosaic_scan_gen
  import mosaic_pkg::*;
#(
  parameter int IMG_W      = DEF_IMG_W,
  parameter int IMG_H      = DEF_IMG_H,
  parameter int TILE_W     = DEF_TILE_W,
  parameter int TILE_H     = DEF_TILE_H,
  parameter int PIPE_DEPTH = DEF_PIPE_DEPTH
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  en,
  input  logic                                                  out_ready,
  output logic                                                  out_valid,
  output logic [width_of(IMG_W)-1:0]                            x,
  output logic [width_of(IMG_H)-1:0]                            y,
  output logic [width_of(IMG_W*IMG_H)-1:0]                      addr,
  output logic [width_of((IMG_W/TILE_W)*(IMG_H/TILE_H))-1:0]    tile_idx,
  output logic                                                  last,
  output logic                                                  done
);

  localparam int NTX = IMG_W / TILE_W;
  localparam int NTY = IMG_H / TILE_H;
  localparam int XW  = width_of(IMG_W);
  localparam int YW  = width_of(IMG_H);
  localparam int AW  = width_of(IMG_W * IMG_H);
  localparam int TW  = width_of(NTX * NTY);
  localparam int DW  = width_of(PIPE_DEPTH);

  localparam logic [COORD_W-1:0] LX_LAST = COORD_W'(TILE_W - 1);
  localparam logic [COORD_W-1:0] LY_LAST = COORD_W'(TILE_H - 1);
  localparam logic [COORD_W-1:0] TX_LAST = COORD_W'(NTX - 1);
  localparam logic [COORD_W-1:0] TY_LAST = COORD_W'(NTY - 1);

  // Constant deltas for stepping x/y/addr without any multiply:
  // end of a tile row jumps back to the tile's left edge one row down,
  // end of a tile (not last in its row) jumps to the top of the next tile.
  localparam logic [XW-1:0] X_ROW_BACK     = XW'(TILE_W - 1);
  localparam logic [YW-1:0] Y_TILE_BACK    = YW'(TILE_H - 1);
  localparam logic [AW-1:0] ADDR_ROW_STEP  = AW'(IMG_W - TILE_W + 1);
  localparam logic [AW-1:0] ADDR_TILE_STEP = AW'(1 - (TILE_H - 1) * IMG_W);
  localparam logic [DW-1:0] DRAIN_LOAD     = DW'(PIPE_DEPTH - 1);

  scan_state_t   state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [TW-1:0] tile_idx_q, tile_idx_d;
  logic [DW-1:0] drain_cnt_q, drain_cnt_d;
  logic          done_q, done_d;

  tile_coord_t   pix_pos, tile_pos;
  logic          pix_wrap, frame_wrap, handshake;

  assign out_valid = (state_q == SCAN) && en;
  assign handshake = out_valid && out_ready;

  tile_raster_counter #(.INNER_N(TILE_W), .OUTER_N(TILE_H)) u_pixel (
    .clk     (clk),
    .reset   (reset),
    .advance (handshake),
    .pos     (pix_pos),
    .wrap    (pix_wrap)
  );

  tile_raster_counter #(.INNER_N(NTX), .OUTER_N(NTY)) u_tile (
    .clk     (clk),
    .reset   (reset),
    .advance (pix_wrap),
    .pos     (tile_pos),
    .wrap    (frame_wrap)
  );

  // Next-state, beat-advance and drain logic for the whole sequencer.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    addr_d      = addr_q;
    tile_idx_d  = tile_idx_q;
    drain_cnt_d = drain_cnt_q;
    done_d      = 1'b0;

    if (handshake) begin
      if (frame_wrap) begin
        x_d        = '0;
        y_d        = '0;
        addr_d     = '0;
        tile_idx_d = '0;
      end else if (pix_wrap) begin
        tile_idx_d = tile_idx_q + 1'b1;
        if (tile_pos.col == TX_LAST) begin
          x_d    = '0;
          y_d    = y_q + 1'b1;
          addr_d = addr_q + 1'b1;
        end else begin
          x_d    = x_q + 1'b1;
          y_d    = y_q - Y_TILE_BACK;
          addr_d = addr_q + ADDR_TILE_STEP;
        end
      end else if (pix_pos.col == LX_LAST) begin
        x_d    = x_q - X_ROW_BACK;
        y_d    = y_q + 1'b1;
        addr_d = addr_q + ADDR_ROW_STEP;
      end else begin
        x_d    = x_q + 1'b1;
        addr_d = addr_q + 1'b1;
      end
    end

    case (state_q)
      SCAN: begin
        if (frame_wrap) begin
          state_d     = DRAIN;
          drain_cnt_d = DRAIN_LOAD;
          done_d      = (PIPE_DEPTH == 1);
        end
      end
      DRAIN: begin
        if (drain_cnt_q == '0) begin
          state_d = FINISHED;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
        done_d = (drain_cnt_q == DW'(1));
      end
      FINISHED: state_d = FINISHED;
      default:  state_d = SCAN;
    endcase
  end

  // State and output registers; reset always restarts at beat 0 of SCAN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      x_q         <= '0;
      y_q         <= '0;
      addr_q      <= '0;
      tile_idx_q  <= '0;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      addr_q      <= addr_d;
      tile_idx_q  <= tile_idx_d;
      drain_cnt_q <= drain_cnt_d;
      done_q      <= done_d;
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign addr     = addr_q;
  assign tile_idx = tile_idx_q;
  assign done     = done_q;
  assign last     = (state_q == SCAN) &&
                    (pix_pos.col == LX_LAST) && (pix_pos.row == LY_LAST) &&
                    (tile_pos.col == TX_LAST) && (tile_pos.row == TY_LAST);

endmodule

// File: tb/tb_mosaic_scan_gen.sv
// Self-checking bench for mosaic_scan_gen: a 2x2-tiled 4x4 mosaic (depth 3)
// and a single-tile 4x4 raster (depth 1), each tracked by a reference model.
module tb_mosaic_scan_gen;

  localparam int NB = 16;

  logic clk;
  logic rst_s [2];
  logic en_s  [2];
  logic rdy_s [2];

  logic       v0, l0, dn0;
  logic [1:0] x0, y0, ti0;
  logic [3:0] a0;
  logic       v1, l1, dn1;
  logic [1:0] x1, y1;
  logic [0:0] ti1;
  logic [3:0] a1;

  int n_checks = 0;
  int n_errors = 0;

  int exp_x [2][NB];
  int exp_y [2][NB];
  int exp_a [2][NB];
  int exp_t [2][NB];
  int pd_of [2];

  int beat      [2];
  int cyc       [2];
  int done_at   [2];
  int done_seen [2];
  int hs_seen   [2];
  bit armed     [2];

  mosaic_scan_gen #(.IMG_W(4), .IMG_H(4), .TILE_W(2), .TILE_H(2), .PIPE_DEPTH(3)) dut0 (
    .clk(clk), .reset(rst_s[0]), .en(en_s[0]), .out_ready(rdy_s[0]),
    .out_valid(v0), .x(x0), .y(y0), .addr(a0), .tile_idx(ti0), .last(l0), .done(dn0)
  );

  mosaic_scan_gen #(.IMG_W(4), .IMG_H(4), .TILE_W(4), .TILE_H(4), .PIPE_DEPTH(1)) dut1 (
    .clk(clk), .reset(rst_s[1]), .en(en_s[1]), .out_ready(rdy_s[1]),
    .out_valid(v1), .x(x1), .y(y1), .addr(a1), .tile_idx(ti1), .last(l1), .done(dn1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  // Expected beat list straight from the scan rules: tiles row-major,
  // pixels raster inside each tile.
  task automatic build_table(input int k, input int tw, input int th, input int pd);
    int i = 0;
    int ntx = 4 / tw;
    pd_of[k] = pd;
    for (int ty = 0; ty < 4 / th; ty++)
      for (int tx = 0; tx < ntx; tx++)
        for (int ly = 0; ly < th; ly++)
          for (int lx = 0; lx < tw; lx++) begin
            exp_x[k][i] = tx * tw + lx;
            exp_y[k][i] = ty * th + ly;
            exp_a[k][i] = exp_y[k][i] * 4 + exp_x[k][i];
            exp_t[k][i] = ty * ntx + tx;
            i++;
          end
  endtask

  // Per-cycle compare against the model, then advance the model using the
  // inputs that will act on the coming clock edge.
  task automatic monitor_step(input int k, input logic r, input logic e, input logic rd,
                              input logic v, input logic [31:0] xo, input logic [31:0] yo,
                              input logic [31:0] ao, input logic [31:0] to,
                              input logic lo, input logic dn);
    logic exp_v;
    cyc[k]++;
    if (armed[k]) begin
      exp_v = (beat[k] < NB) && e;
      checkOutput($sformatf("d%0d_valid", k), 32'(v), 32'(exp_v));
      checkOutput($sformatf("d%0d_done", k), 32'(dn), (cyc[k] == done_at[k]) ? 1 : 0);
      if (dn === 1'b1) done_seen[k]++;
      if (v === 1'b1 && rd) hs_seen[k]++;
      if (exp_v) begin
        checkOutput($sformatf("d%0d_x[%0d]", k, beat[k]), xo, exp_x[k][beat[k]]);
        checkOutput($sformatf("d%0d_y[%0d]", k, beat[k]), yo, exp_y[k][beat[k]]);
        checkOutput($sformatf("d%0d_addr[%0d]", k, beat[k]), ao, exp_a[k][beat[k]]);
        checkOutput($sformatf("d%0d_tile[%0d]", k, beat[k]), to, exp_t[k][beat[k]]);
        checkOutput($sformatf("d%0d_last[%0d]", k, beat[k]), 32'(lo), (beat[k] == NB - 1) ? 1 : 0);
      end
    end
    if (r) begin
      beat[k]      = 0;
      done_at[k]   = -1;
      done_seen[k] = 0;
      hs_seen[k]   = 0;
      armed[k]     = 1'b1;
    end else if (armed[k] && beat[k] < NB && e && rd) begin
      if (beat[k] == NB - 1) done_at[k] = cyc[k] + pd_of[k];
      beat[k]++;
    end
  endtask

  always @(negedge clk)
    monitor_step(0, rst_s[0], en_s[0], rdy_s[0], v0, 32'(x0), 32'(y0), 32'(a0), 32'(ti0), l0, dn0);

  always @(negedge clk)
    monitor_step(1, rst_s[1], en_s[1], rdy_s[1], v1, 32'(x1), 32'(y1), 32'(a1), 32'(ti1), l1, dn1);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int k, input int rpct, input int epct);
    rdy_s[k] = ($urandom_range(0, 99) < rpct);
    en_s[k]  = ($urandom_range(0, 99) < epct);
    tick();
  endtask

  task automatic do_reset(input int k);
    rst_s[k] = 1'b1;
    en_s[k]  = 1'b0;
    tick();
    rst_s[k] = 1'b0;
  endtask

  task automatic run_until_beat(input int k, input int target, input int rpct, input int epct);
    int guard = 0;
    while (beat[k] < target && guard < 2000) begin
      applyStimulus(k, rpct, epct);
      guard++;
    end
    if (beat[k] < target) checkOutput($sformatf("d%0d_timeout_beat", k), beat[k], target);
  endtask

  task automatic run_until_finished(input int k, input int rpct, input int epct);
    int guard = 0;
    while (!(beat[k] == NB && done_seen[k] > 0) && guard < 3000) begin
      applyStimulus(k, rpct, epct);
      guard++;
    end
    if (guard >= 3000) checkOutput($sformatf("d%0d_timeout_done", k), 0, 1);
    repeat (4) applyStimulus(k, rpct, epct);
  endtask

  task automatic check_frame(input int k, input string tag);
    checkOutput({tag, "_beats"}, hs_seen[k], NB);
    checkOutput({tag, "_dones"}, done_seen[k], 1);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_s[k] = 1'b1;
      en_s[k]  = 1'b0;
      rdy_s[k] = 1'b0;
      done_at[k] = -1;
    end
    build_table(0, 2, 2, 3);
    build_table(1, 4, 4, 1);
    repeat (2) tick();

    // Reset state of the tiled instance.
    checkOutput("reset_addr", 32'(a0), 0);
    checkOutput("reset_valid", 32'(v0), 0);
    checkOutput("reset_done", 32'(dn0), 0);
    checkOutput("reset_last", 32'(l0), 0);

    // Continuous flow.
    do_reset(0);
    run_until_finished(0, 100, 100);
    check_frame(0, "flow");

    // Back-pressure hold at addr 6.
    do_reset(0);
    run_until_beat(0, 6, 100, 100);
    rdy_s[0] = 1'b0;
    en_s[0]  = 1'b1;
    repeat (5) begin
      tick();
      checkOutput("hold_addr", 32'(a0), 6);
      checkOutput("hold_x", 32'(x0), 2);
      checkOutput("hold_y", 32'(y0), 1);
      checkOutput("hold_valid", 32'(v0), 1);
    end
    rdy_s[0] = 1'b1;
    tick();
    checkOutput("after_hold_addr", 32'(a0), 7);
    run_until_finished(0, 70, 100);
    check_frame(0, "hold");

    // Enable drop at addr 9, then enable low through the drain.
    do_reset(0);
    run_until_beat(0, 9, 60, 100);
    rdy_s[0] = 1'b1;
    en_s[0]  = 1'b0;
    repeat (4) begin
      tick();
      checkOutput("freeze_valid", 32'(v0), 0);
      checkOutput("freeze_addr", 32'(a0), 9);
    end
    run_until_beat(0, NB, 60, 100);
    run_until_finished(0, 50, 0);
    check_frame(0, "en_drop");

    // Reset mid-scan at addr 12.
    do_reset(0);
    run_until_beat(0, 10, 100, 100);
    rst_s[0] = 1'b1;
    tick();
    rst_s[0] = 1'b0;
    en_s[0]  = 1'b0;
    checkOutput("midscan_reset_addr", 32'(a0), 0);
    checkOutput("midscan_reset_tile", 32'(ti0), 0);

    // Reset one cycle into the drain: the aborted done must never appear.
    run_until_beat(0, NB, 100, 100);
    rst_s[0] = 1'b1;
    en_s[0]  = 1'b0;
    tick();
    rst_s[0] = 1'b0;
    repeat (6) tick();
    checkOutput("abort_done", done_seen[0], 0);
    checkOutput("abort_addr", 32'(a0), 0);

    // Consumer loop: done latches en low.
    do_reset(0);
    for (int i = 0; i < 80; i++) begin
      rdy_s[0] = ($urandom_range(0, 99) < 70);
      en_s[0]  = (done_seen[0] == 0);
      tick();
    end
    check_frame(0, "loop");
    checkOutput("loop_valid_off", 32'(v0), 0);

    // Extra randomized frames.
    for (int f = 0; f < 3; f++) begin
      do_reset(0);
      run_until_finished(0, 55, 75);
      check_frame(0, $sformatf("rand%0d", f));
    end

    // Single tile, depth 1: plain raster.
    do_reset(1);
    run_until_finished(1, 65, 90);
    check_frame(1, "raster");
    checkOutput("raster_valid_off", 32'(v1), 0);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end

endmodule
